// File: rtl/ahblite_slave_mux_if.sv
// Bus bundle between the address decoder / slaves and the AHB-Lite
// data-phase return mux. The mux sits on the "slave" side of this
// bundle; whatever drives the decoder selects and slave responses uses
// the "master" view.
interface ahblite_slave_mux_if;
  logic [1:0]  HTRANS;
  logic        P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL, P6_HSEL;
  logic        P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT;
  logic        P4_HREADYOUT, P5_HREADYOUT, P6_HREADYOUT;
  logic        P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP, P6_HRESP;
  logic [31:0] P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA;
  logic [31:0] P4_HRDATA, P5_HRDATA, P6_HRDATA;
  logic        HREADY;
  logic        HRESP;
  logic [31:0] HRDATA;
  logic        TIMEOUT_CLR;
  logic        TIMEOUT;
  logic [7:0]  ERR_CNT;

  modport slave (
    input  HTRANS,
    input  P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL, P6_HSEL,
    input  P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
    input  P4_HREADYOUT, P5_HREADYOUT, P6_HREADYOUT,
    input  P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP, P6_HRESP,
    input  P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
    input  P4_HRDATA, P5_HRDATA, P6_HRDATA,
    input  TIMEOUT_CLR,
    output HREADY, HRESP, HRDATA, TIMEOUT, ERR_CNT
  );

  modport master (
    output HTRANS,
    output P0_HSEL, P1_HSEL, P2_HSEL, P3_HSEL, P4_HSEL, P5_HSEL, P6_HSEL,
    output P0_HREADYOUT, P1_HREADYOUT, P2_HREADYOUT, P3_HREADYOUT,
    output P4_HREADYOUT, P5_HREADYOUT, P6_HREADYOUT,
    output P0_HRESP, P1_HRESP, P2_HRESP, P3_HRESP, P4_HRESP, P5_HRESP, P6_HRESP,
    output P0_HRDATA, P1_HRDATA, P2_HRDATA, P3_HRDATA,
    output P4_HRDATA, P5_HRDATA, P6_HRDATA,
    output TIMEOUT_CLR,
    input  HREADY, HRESP, HRDATA, TIMEOUT, ERR_CNT
  );
endinterface

// File: rtl/ahblite_slave_mux.sv
// AHB-Lite data-phase return mux. Registers the decoder's port select on
// each accepted address phase, routes the selected slave's response back
// to the master, implements the default (ERROR) slave for unmapped
// transfers, and watches for long stalls and counts default-slave errors.
module ahblite_slave_mux #(
  parameter bit Port0_en       = 1'b1,
  parameter bit Port1_en       = 1'b1,
  parameter bit Port2_en       = 1'b1,
  parameter bit Port3_en       = 1'b1,
  parameter bit Port4_en       = 1'b1,
  parameter bit Port5_en       = 1'b1,
  parameter bit Port6_en       = 1'b1,
  parameter int TIMEOUT_CYCLES = 256
) (
  input logic               HCLK,
  input logic               HRESET,
  ahblite_slave_mux_if.slave bus
);

  localparam int          NPORT   = 7;
  localparam logic [6:0]  PORT_EN = {Port6_en, Port5_en, Port4_en, Port3_en,
                                     Port2_en, Port1_en, Port0_en};
  localparam logic [15:0] TO_LIM  = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } def_state_t;

  // Port-indexed views of the individually named bus signals.
  logic [6:0]  hsel_v;
  logic [6:0]  hrdy_v;
  logic [6:0]  hresp_v;
  logic [31:0] hrdata_a [NPORT];

  assign hsel_v  = {bus.P6_HSEL, bus.P5_HSEL, bus.P4_HSEL, bus.P3_HSEL,
                    bus.P2_HSEL, bus.P1_HSEL, bus.P0_HSEL};
  assign hrdy_v  = {bus.P6_HREADYOUT, bus.P5_HREADYOUT, bus.P4_HREADYOUT,
                    bus.P3_HREADYOUT, bus.P2_HREADYOUT, bus.P1_HREADYOUT,
                    bus.P0_HREADYOUT};
  assign hresp_v = {bus.P6_HRESP, bus.P5_HRESP, bus.P4_HRESP, bus.P3_HRESP,
                    bus.P2_HRESP, bus.P1_HRESP, bus.P0_HRESP};
  assign hrdata_a[0] = bus.P0_HRDATA;
  assign hrdata_a[1] = bus.P1_HRDATA;
  assign hrdata_a[2] = bus.P2_HRDATA;
  assign hrdata_a[3] = bus.P3_HRDATA;
  assign hrdata_a[4] = bus.P4_HRDATA;
  assign hrdata_a[5] = bus.P5_HRDATA;
  assign hrdata_a[6] = bus.P6_HRDATA;

  // Only HTRANS[1] distinguishes an active transfer from IDLE/BUSY here.
  logic unused_htrans0;
  assign unused_htrans0 = bus.HTRANS[0];

  // State
  logic [7:0]  dsel_q, dsel_d;     // one-hot: [6:0] ports, [7] default slave
  logic [15:0] stall_q, stall_d;
  logic        timeout_q, timeout_d;
  def_state_t  fsm_q;
  logic        def_hready_q;
  logic        def_hresp_q;
  logic [7:0]  err_cnt_q;

  // Combinational bus outputs
  logic        hready_o;
  logic        hresp_o;
  logic [31:0] hrdata_o;

  // Disabled ports are masked out so their HSEL can never win.
  logic [6:0] req;
  genvar gi;
  generate
    for (gi = 0; gi < NPORT; gi++) begin : g_req
      assign req[gi] = hsel_v[gi] & PORT_EN[gi];
    end
  endgenerate

  // Next select: lowest-index enabled request, else default slave for an
  // active transfer, else idle (all zero).
  logic [7:0] next_sel;
  always_comb begin
    next_sel = 8'd0;
    if (req != 7'd0) begin
      next_sel[6:0] = req & (~req + 7'd1);
    end else if (bus.HTRANS[1]) begin
      next_sel[7] = 1'b1;
    end
  end

  // Return-path mux driven purely by the registered data-phase select.
  always_comb begin
    hready_o = 1'b1;
    hresp_o  = 1'b0;
    hrdata_o = 32'd0;
    if (dsel_q[7]) begin
      hready_o = def_hready_q;
      hresp_o  = def_hresp_q;
    end else begin
      for (int k = 0; k < NPORT; k++) begin
        if (dsel_q[k]) begin
          hready_o = hrdy_v[k];
          hresp_o  = hresp_v[k];
          hrdata_o = hrdata_a[k];
        end
      end
    end
  end

  // Next-state for the select register and the stall/timeout monitor.
  always_comb begin
    dsel_d = hready_o ? next_sel : dsel_q;

    stall_d = stall_q;
    if (hready_o) begin
      stall_d = 16'd0;
    end else if ((dsel_q[6:0] != 7'd0) && (stall_q != TO_LIM)) begin
      stall_d = stall_q + 16'd1;
    end

    // A set on this edge wins over a simultaneous clear request.
    timeout_d = timeout_q;
    if (stall_q == TO_LIM) begin
      timeout_d = 1'b1;
    end else if (bus.TIMEOUT_CLR) begin
      timeout_d = 1'b0;
    end
  end

  // Select register and monitor flops.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_q    <= 8'd0;
      stall_q   <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      dsel_q    <= dsel_d;
      stall_q   <= stall_d;
      timeout_q <= timeout_d;
    end
  end

  // Default-slave FSM: two-cycle ERROR response with registered outputs,
  // chaining straight into another ERROR when the next transfer is also
  // unmapped; every ERR1 entry bumps the saturating error counter.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      fsm_q        <= ST_IDLE;
      def_hready_q <= 1'b1;
      def_hresp_q  <= 1'b0;
      err_cnt_q    <= 8'd0;
    end else begin
      case (fsm_q)
        ST_ERR1: begin
          fsm_q        <= ST_ERR2;
          def_hready_q <= 1'b1;
          def_hresp_q  <= 1'b1;
        end
        default: begin
          if (hready_o && next_sel[7]) begin
            fsm_q        <= ST_ERR1;
            def_hready_q <= 1'b0;
            def_hresp_q  <= 1'b1;
            if (err_cnt_q != 8'hFF) begin
              err_cnt_q <= err_cnt_q + 8'd1;
            end
          end else begin
            fsm_q        <= ST_IDLE;
            def_hready_q <= 1'b1;
            def_hresp_q  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.HREADY  = hready_o;
  assign bus.HRESP   = hresp_o;
  assign bus.HRDATA  = hrdata_o;
  assign bus.TIMEOUT = timeout_q;
  assign bus.ERR_CNT = err_cnt_q;

endmodule
